// File: rtl/pipe_stall_ctrl.sv
// Central pipeline stall controller: merges ID/EX hazard requests with a multi-cycle EX sequencer.
// stop is combinational from inputs and registered state; mc_busy/mc_done/stall_cnt come from flops.
module pipe_stall_ctrl #(
  parameter int STOP_W = 6,
  parameter int CNT_W  = 6,
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallreq_id,
  input  logic              stallreq_ex,
  input  logic              mc_start,
  input  logic [CNT_W-1:0]  mc_cycles,
  input  logic              flush,
  output logic [STOP_W-1:0] stop,
  output logic              mc_busy,
  output logic              mc_done,
  output logic [PERF_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [STOP_W-1:0] STOP_EX = STOP_W'(4'b1111);
  localparam logic [STOP_W-1:0] STOP_ID = STOP_W'(3'b111);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;
  logic              mc_accept;
  logic              ex_stall;

  always_comb begin
    mc_accept = mc_start && (mc_cycles != '0) && (state_q == IDLE);
    ex_stall  = stallreq_ex || mc_accept || (state_q == BUSY);
    // EX stall freezes EX/MEM too; an ID-only stall lets a bubble fall into EX/MEM.
    if (rst || flush) begin
      stop = '0;
    end else if (ex_stall) begin
      stop = STOP_EX;
    end else if (stallreq_id) begin
      stop = STOP_ID;
    end else begin
      stop = '0;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (mc_accept) begin
            if (mc_cycles == CNT_W'(1)) begin
              state_d = DONE;
            end else begin
              state_d = BUSY;
              cnt_d   = mc_cycles - CNT_W'(1);
            end
          end
        end
        BUSY: begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = DONE;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
    if (stop[0] && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + PERF_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign mc_busy   = (state_q == BUSY);
  assign mc_done   = (state_q == DONE);
  assign stall_cnt = stall_cnt_q;

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
Central stall controller for the 5-stage pipeline. It generates the `StopWidth stop vector consumed by every inter-stage register: bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 WB; `Stop=1, `NoStop=0. It merges single-cycle hazard requests from ID and EX with a multi-cycle EX occupancy sequencer used for divide/multiply-accumulate ops. It also keeps a saturating stall-cycle counter for performance monitoring.

Parameters:
STOP_W, 6, width of stop vector (matches `StopWidth)
CNT_W, 6, width of multi-cycle length field
PERF_W, 32, width of stall-cycle counter

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
stallreq_id  input  1  ID hazard request (load-use), valid same cycle
stallreq_ex  input  1  EX single-cycle stall request, valid same cycle
mc_start  input  1  EX launches multi-cycle op this cycle
mc_cycles  input  CNT_W  total stall cycles N for the op, sampled with mc_start
flush  input  1  pipeline flush (exception/redirect)
stop  output  STOP_W  stall vector to PC and pipeline registers
mc_busy  output  1  sequencer in BUSY state (registered)
mc_done  output  1  one-cycle pulse: multi-cycle op complete, EX result may advance
stall_cnt  output  PERF_W  cycles with stop[0]==1 since reset

Behaviour:
- Reset values: state IDLE, internal cnt=0, mc_busy=0, mc_done=0, stall_cnt=0. While rst=1, stop is forced to 0.
- FSM states: IDLE, BUSY, DONE. Registered; cnt is a CNT_W down-counter.
- IDLE: on mc_start with N=mc_cycles, the EX stall is asserted combinationally in the start cycle.
  - N>=2: load cnt=N-1 and go to BUSY.
  - N==1: go to DONE.
  - N==0: ignored, no stall, no mc_done.
- BUSY: EX stall asserted. If cnt==1, go to DONE; else cnt<=cnt-1. BUSY therefore lasts N-1 cycles, for N total stalled cycles.
- DONE: no mc stall. mc_done=1 for exactly this cycle. Next state IDLE. A mc_start in DONE is ignored.
- mc_start while BUSY or DONE: ignored; cnt is not reloaded.
- ex_stall = stallreq_ex | (mc_start & N!=0 & state==IDLE) | (state==BUSY).
- stop priority, combinational:
  - flush=1 → 6'b000000.
  - else ex_stall → 6'b001111 (PC, IF/ID, ID/EX, EX/MEM held). The ID/EX register holds; EX/MEM receives no bubble because EX itself stalls.
  - else stallreq_id → 6'b000111 (ID/EX inserts a NOP bubble, since stop[2]=1 and stop[3]=0).
  - else 6'b000000.
- Bits 4 and 5 are never asserted by this block.
- flush: on the next edge state returns to IDLE, cnt=0, mc_done=0. A mc_start in the same cycle as flush is ignored. stall_cnt is not cleared by flush.
- stall_cnt: increments by 1 on each edge where stop[0]==1 and rst==0. It saturates at all-ones; no wrap.
- Reset mid-BUSY: on the next edge state is IDLE and all registered outputs return to reset values. stop is 0 during reset.
- No combinational path from any output back to any input.

Test Plan:
- Reset: hold rst 3 cycles with stallreq_ex=1 → stop=0, mc_busy=0, stall_cnt=0. Release with all inputs 0 → stop=0.
- Load-use: stallreq_id=1 for 1 cycle → stop=6'b000111 that cycle only, stall_cnt=1. With stallreq_id=1 and stallreq_ex=1 together → stop=6'b001111.
- Multi-cycle N=4: mc_start=1, mc_cycles=4 in cycle t → stop=6'b001111 in cycles t..t+3, mc_busy=1 in t+1..t+3, mc_done=1 only in t+4 with stop=0, stall_cnt=4. A second mc_start in t+2 is ignored (no extension).
- Boundaries:
  - N=1 → one stalled cycle t, then mc_done in t+1.
  - N=0 → no stall, no mc_done.
  - N=63 → 63 stalled cycles, then mc_done.
- Flush mid-op: N=10 start at t, flush=1 at t+3 → stop=0 at t+3, IDLE/mc_busy=0 at t+4, no mc_done. mc_start coincident with flush is ignored.
- Saturation: with PERF_W=4, hold stallreq_ex=1 for 20 cycles → stall_cnt reaches 15 and stays 15. Then reset mid-BUSY → stall_cnt=0, mc_busy=0 after one edge.
